// File: rtl/match_coord_collector.sv
// Collects match coordinates and SAD scores over one frame and streams them out
// over valid/ready: ALL mode buffers every match, BEST mode keeps the lowest SAD.
module match_coord_collector #(
  parameter int unsigned X_W   = 10,
  parameter int unsigned Y_W   = 9,
  parameter int unsigned SAD_W = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_frame_start,
  input  logic             i_frame_end,
  input  logic             i_mode,
  input  logic             i_match_valid,
  input  logic [X_W-1:0]   i_match_x,
  input  logic [Y_W-1:0]   i_match_y,
  input  logic [SAD_W-1:0] i_match_sad,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [X_W-1:0]   o_out_x,
  output logic [Y_W-1:0]   o_out_y,
  output logic [SAD_W-1:0] o_out_sad,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_match_count,
  output logic             o_overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [SAD_W-1:0] sad;
  } entry_t;

  localparam entry_t SENTINEL = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FLUSH   = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic             r_mode;
  logic             r_have_best;
  entry_t           r_best;
  logic [CNT_W-1:0] r_match_count;
  logic             r_overflow;
  logic             r_frame_done;

  logic   w_pop;
  logic   w_push;
  logic   w_drop;
  logic   w_match;
  logic   w_start;
  logic   w_full;
  logic   w_no_match;
  entry_t w_match_entry;
  entry_t w_push_data;

  assign w_match_entry = {i_match_x, i_match_y, i_match_sad};
  assign w_pop         = (r_occ != '0) && i_out_ready;
  assign w_match       = (r_state == S_COLLECT) && i_match_valid;
  assign w_start       = (r_state == S_IDLE) && i_frame_start;
  // Full is judged after a same-cycle pop, so push+pop at full still fits.
  assign w_full        = (r_occ == OCC_W'(DEPTH)) && !w_pop;
  assign w_no_match    = (r_match_count == '0);

  always_comb begin
    w_next      = r_state;
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_push_data = SENTINEL;
    case (r_state)
      S_IDLE: begin
        if (i_frame_start) w_next = S_COLLECT;
      end
      S_COLLECT: begin
        if (w_match && !r_mode) begin
          if (w_full) begin
            w_drop = 1'b1;
          end else begin
            w_push      = 1'b1;
            w_push_data = w_match_entry;
          end
        end
        if (i_frame_end) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        // One-shot push of the frame result: best entry, or sentinel for an empty frame.
        w_next = S_DRAIN;
        if (r_mode) begin
          w_push      = 1'b1;
          w_push_data = w_no_match ? SENTINEL : r_best;
        end else if (w_no_match) begin
          w_push = 1'b1;
        end
      end
      S_DRAIN: begin
        if ((r_occ == '0) || ((r_occ == OCC_W'(1)) && w_pop)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_occ         <= '0;
      r_mode        <= 1'b0;
      r_have_best   <= 1'b0;
      r_best        <= SENTINEL;
      r_match_count <= '0;
      r_overflow    <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_frame_done <= (r_state == S_DRAIN) && (w_next == S_IDLE);
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
      if (w_start) begin
        r_mode        <= i_mode;
        r_have_best   <= 1'b0;
        r_best        <= SENTINEL;
        r_match_count <= '0;
        r_overflow    <= 1'b0;
      end else begin
        if (w_match && (r_match_count != '1)) r_match_count <= r_match_count + CNT_W'(1);
        if (w_drop) r_overflow <= 1'b1;
        // Strict compare: on a tie the earlier match stays.
        if (w_match && r_mode && (!r_have_best || (i_match_sad < r_best.sad))) begin
          r_best      <= w_match_entry;
          r_have_best <= 1'b1;
        end
      end
    end
  end

  // Storage array needs no reset: the head is masked to the sentinel when empty.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  assign o_out_valid   = (r_occ != '0);
  assign o_out_x       = o_out_valid ? r_mem[r_rptr].x   : SENTINEL.x;
  assign o_out_y       = o_out_valid ? r_mem[r_rptr].y   : SENTINEL.y;
  assign o_out_sad     = o_out_valid ? r_mem[r_rptr].sad : SENTINEL.sad;
  assign o_busy        = (r_state != S_IDLE);
  assign o_frame_done  = r_frame_done;
  assign o_match_count = r_match_count;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_match_coord_collector.sv
// Bench for match_coord_collector: directed frames plus randomized frames checked
// against a queue-level model of the collection rules.
module tb_match_coord_collector;

  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned SAD_W = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned E_W   = X_W + Y_W + SAD_W;
  localparam logic [E_W-1:0] SENT = '1;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b1;
  logic             i_frame_start = 1'b0;
  logic             i_frame_end = 1'b0;
  logic             i_mode = 1'b0;
  logic             i_match_valid = 1'b0;
  logic [X_W-1:0]   i_match_x = '0;
  logic [Y_W-1:0]   i_match_y = '0;
  logic [SAD_W-1:0] i_match_sad = '0;
  logic             i_out_ready = 1'b0;
  logic             o_out_valid;
  logic [X_W-1:0]   o_out_x;
  logic [Y_W-1:0]   o_out_y;
  logic [SAD_W-1:0] o_out_sad;
  logic             o_busy;
  logic             o_frame_done;
  logic [CNT_W-1:0] o_match_count;
  logic             o_overflow;

  match_coord_collector #(
    .X_W(X_W), .Y_W(Y_W), .SAD_W(SAD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_start(i_frame_start),
    .i_frame_end(i_frame_end), .i_mode(i_mode), .i_match_valid(i_match_valid),
    .i_match_x(i_match_x), .i_match_y(i_match_y), .i_match_sad(i_match_sad),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_x(o_out_x),
    .o_out_y(o_out_y), .o_out_sad(o_out_sad), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_match_count(o_match_count), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  int ncyc  = 0;

  logic [E_W-1:0] got_q[$];
  int             got_cyc[$];
  int             fd_q[$];
  logic [E_W-1:0] exp_q[$];
  int             exp_cyc[$];
  logic [E_W-1:0] mq[$];
  int             mcount;
  bit             movf;
  bit             m_mode;
  bit             m_have;
  logic [E_W-1:0] m_best;

  // Record accepted beats and frame_done pulses half a cycle before the edge.
  always @(negedge i_clk) begin
    ncyc++;
    if (o_out_valid && i_out_ready) begin
      got_q.push_back({o_out_x, o_out_y, o_out_sad});
      got_cyc.push_back(ncyc);
    end
    if (o_frame_done) fd_q.push_back(ncyc);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic begin_frame(input bit m);
    got_q.delete(); got_cyc.delete(); fd_q.delete();
    exp_q.delete(); exp_cyc.delete(); mq.delete();
    mcount = 0; movf = 0; m_mode = m; m_have = 0; m_best = SENT;
    i_mode = m; i_frame_start = 1'b1; i_match_valid = 1'b0; i_frame_end = 1'b0;
    tick();
    i_frame_start = 1'b0;
  endtask

  // One COLLECT cycle; the model applies the pop first, then the match.
  task automatic col(input bit v, input logic [E_W-1:0] e, input bit rdy, input bit fe, input bit fs);
    i_match_valid = v; {i_match_x, i_match_y, i_match_sad} = e;
    i_out_ready = rdy; i_frame_end = fe; i_frame_start = fs;
    i_mode = 1'($urandom_range(1));
    if (rdy && mq.size() != 0) void'(mq.pop_front());
    if (v) begin
      if (mcount < (1 << CNT_W) - 1) mcount++;
      if (!m_mode) begin
        if (mq.size() < int'(DEPTH)) begin
          mq.push_back(e); exp_q.push_back(e); exp_cyc.push_back(ncyc + 2);
        end else begin
          movf = 1;
        end
      end else if (!m_have || e[SAD_W-1:0] < m_best[SAD_W-1:0]) begin
        m_best = e; m_have = 1;
      end
    end
    if (fe) begin
      if (m_mode) begin
        exp_q.push_back(m_have ? m_best : SENT); exp_cyc.push_back(ncyc + 3);
      end else if (mcount == 0) begin
        exp_q.push_back(SENT); exp_cyc.push_back(ncyc + 3);
      end
    end
    tick();
    i_match_valid = 1'b0; i_frame_end = 1'b0; i_frame_start = 1'b0;
  endtask

  task automatic drain(input int pct, output bit to);
    to = 1;
    for (int i = 0; i < 400; i++) begin
      i_out_ready = (int'($urandom_range(99)) < pct);
      tick();
      if (fd_q.size() != 0) begin
        to = 0;
        break;
      end
    end
    i_out_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset();
    #2 i_rst_n = 1'b0;
    #2;
    n_vec++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", o_out_valid); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", o_busy); end
    n_vec++; if (o_frame_done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b exp 0", o_frame_done); end
    n_vec++; if (o_match_count !== 16'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", o_match_count); end
    n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b exp 0", o_overflow); end
    n_vec++; if ({o_out_x, o_out_y, o_out_sad} !== {10'd1023, 9'd511, 16'd65535}) begin
      n_err++; $display("FAIL rst_sentinel got %0d,%0d,%0d exp 1023,511,65535", o_out_x, o_out_y, o_out_sad);
    end
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_all_basic(input string tag);
    bit to;
    begin_frame(0);
    n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL %s_busy got %b exp 1", tag, o_busy); end
    col(1, {10'd10, 9'd5, 16'd40}, 1, 0, 0);
    col(0, '0, 1, 0, 0);
    col(1, {10'd20, 9'd5, 16'd7}, 1, 0, 0);
    col(1, {10'd30, 9'd6, 16'd9}, 1, 0, 0);
    col(0, '0, 1, 1, 0);
    drain(100, to);
    n_vec++; if (to) begin n_err++; $display("FAIL %s_timeout got no frame_done exp one", tag); end
    n_vec++; if (got_q.size() != 3) begin n_err++; $display("FAIL %s_len got %0d exp 3", tag, got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL %s_out%0d got %h exp %h", tag, i, got_q[i], exp_q[i]); end
      n_vec++; if (got_cyc[i] != exp_cyc[i]) begin n_err++; $display("FAIL %s_lat%0d got cyc %0d exp %0d", tag, i, got_cyc[i], exp_cyc[i]); end
    end
    n_vec++; if (o_match_count !== 16'd3) begin n_err++; $display("FAIL %s_count got %0d exp 3", tag, o_match_count); end
    n_vec++; if (fd_q.size() != 1) begin n_err++; $display("FAIL %s_done got %0d pulses exp 1", tag, fd_q.size()); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL %s_idle got busy %b exp 0", tag, o_busy); end
  endtask

  task automatic test_overflow();
    bit to;
    begin_frame(0);
    for (int i = 0; i < 10; i++) col(1, {X_W'(i + 1), Y_W'(2 * i), SAD_W'(100 + i)}, 0, 0, 0);
    col(0, '0, 0, 1, 0);
    n_vec++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL t2_ovf got %b exp 1", o_overflow); end
    n_vec++; if (o_match_count !== 16'd10) begin n_err++; $display("FAIL t2_count got %0d exp 10", o_match_count); end
    drain(100, to);
    n_vec++; if (to) begin n_err++; $display("FAIL t2_timeout got no frame_done exp one"); end
    n_vec++; if (got_q.size() != 8) begin n_err++; $display("FAIL t2_len got %0d exp 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== {X_W'(i + 1), Y_W'(2 * i), SAD_W'(100 + i)}) begin
        n_err++; $display("FAIL t2_out%0d got %h exp x=%0d", i, got_q[i], i + 1);
      end
    end
    n_vec++; if (fd_q.size() != 1) begin n_err++; $display("FAIL t2_done got %0d pulses exp 1", fd_q.size()); end
  endtask

  task automatic test_best();
    bit to;
    begin_frame(1);
    col(1, {10'd1, 9'd7, 16'd40}, 1, 0, 0);
    col(1, {10'd3, 9'd7, 16'd12}, 1, 0, 0);
    col(1, {10'd4, 9'd7, 16'd12}, 1, 0, 0);
    col(1, {10'd5, 9'd7, 16'd30}, 1, 0, 0);
    n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL t3_early got %0d beats exp 0", got_q.size()); end
    col(0, '0, 1, 1, 0);
    drain(100, to);
    n_vec++; if (to) begin n_err++; $display("FAIL t3_timeout got no frame_done exp one"); end
    n_vec++; if (got_q.size() != 1) begin n_err++; $display("FAIL t3_len got %0d exp 1", got_q.size()); end
    else begin
      n_vec++; if (got_q[0] !== {10'd3, 9'd7, 16'd12}) begin n_err++; $display("FAIL t3_best got %h exp x=3 sad=12", got_q[0]); end
      n_vec++; if (fd_q.size() != 1 || fd_q[0] <= got_cyc[0]) begin
        n_err++; $display("FAIL t3_done got %0d pulses exp 1 after accept", fd_q.size());
      end
    end
    n_vec++; if (o_match_count !== 16'd4) begin n_err++; $display("FAIL t3_count got %0d exp 4", o_match_count); end
  endtask

  task automatic test_empty();
    bit to;
    for (int m = 0; m < 2; m++) begin
      begin_frame(1'(m));
      col(0, '0, 1, 0, 0);
      col(0, '0, 1, 0, 0);
      col(0, '0, 1, 1, 0);
      drain(100, to);
      n_vec++; if (to) begin n_err++; $display("FAIL t4_timeout mode %0d got no frame_done exp one", m); end
      n_vec++; if (got_q.size() != 1) begin n_err++; $display("FAIL t4_len mode %0d got %0d exp 1", m, got_q.size()); end
      else begin
        n_vec++; if (got_q[0] !== {10'd1023, 9'd511, 16'd65535}) begin n_err++; $display("FAIL t4_sent mode %0d got %h exp sentinel", m, got_q[0]); end
      end
      n_vec++; if (o_match_count !== 16'd0) begin n_err++; $display("FAIL t4_count mode %0d got %0d exp 0", m, o_match_count); end
    end
  endtask

  task automatic test_full_pop_edge();
    bit to;
    logic [E_W-1:0] last;
    last = {10'd777, 9'd77, 16'd7};
    begin_frame(0);
    for (int i = 0; i < int'(DEPTH); i++) col(1, {X_W'(50 + i), Y_W'(i), SAD_W'(i)}, 0, 0, 0);
    col(1, last, 1, 1, 0);
    n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL t5_ovf got %b exp 0", o_overflow); end
    drain(100, to);
    n_vec++; if (to) begin n_err++; $display("FAIL t5_timeout got no frame_done exp one"); end
    n_vec++; if (got_q.size() != DEPTH + 1) begin n_err++; $display("FAIL t5_len got %0d exp %0d", got_q.size(), DEPTH + 1); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL t5_out%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (got_q.size() == 0 || got_q[got_q.size() - 1] !== last) begin n_err++; $display("FAIL t5_last got other exp %h", last); end
  endtask

  task automatic test_reset_mid_drain();
    begin_frame(0);
    col(1, {10'd8, 9'd8, 16'd8}, 0, 0, 0);
    col(1, {10'd9, 9'd9, 16'd9}, 0, 0, 0);
    col(0, '0, 0, 1, 0);
    col(0, '0, 0, 0, 0);
    n_vec++; if (o_out_valid !== 1'b1 || o_busy !== 1'b1) begin
      n_err++; $display("FAIL t6_pre got valid %b busy %b exp 1 1", o_out_valid, o_busy);
    end
    #2 i_rst_n = 1'b0;
    #1;
    n_vec++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL t6_valid got %b exp 0", o_out_valid); end
    n_vec++; if (o_out_x !== 10'd1023) begin n_err++; $display("FAIL t6_x got %0d exp 1023", o_out_x); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL t6_busy got %b exp 0", o_busy); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    test_all_basic("t6_t1");
  endtask

  task automatic test_random();
    bit to;
    bit m;
    int pct;
    int len;
    logic [E_W-1:0] e;
    logic [SAD_W-1:0] sad;
    for (int f = 0; f < 8; f++) begin
      m = 1'($urandom_range(1));
      begin_frame(m);
      pct = 20 + int'($urandom_range(80));
      len = 3 + int'($urandom_range(25));
      for (int c = 0; c <= len; c++) begin
        sad = ($urandom_range(9) == 0) ? '1 : SAD_W'($urandom_range(20));
        e = {X_W'($urandom), Y_W'($urandom), sad};
        col(($urandom_range(99) < 60) && (f != 3), e, (int'($urandom_range(99)) < pct),
            c == len, $urandom_range(15) == 0);
      end
      drain(pct, to);
      n_vec++; if (to) begin n_err++; $display("FAIL rnd%0d_timeout got no frame_done exp one", f); end
      n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd%0d_len got %0d exp %0d", f, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd%0d_out%0d got %h exp %h", f, i, got_q[i], exp_q[i]); end
      end
      n_vec++; if (o_match_count !== CNT_W'(mcount)) begin n_err++; $display("FAIL rnd%0d_count got %0d exp %0d", f, o_match_count, mcount); end
      n_vec++; if (o_overflow !== movf) begin n_err++; $display("FAIL rnd%0d_ovf got %b exp %b", f, o_overflow, movf); end
      n_vec++; if (fd_q.size() != 1 || (got_q.size() != 0 && fd_q[0] <= got_cyc[got_q.size() - 1])) begin
        n_err++; $display("FAIL rnd%0d_done got %0d pulses exp 1 after last beat", f, fd_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_basic("t1");
    test_overflow();
    test_best();
    test_empty();
    test_full_pop_edge();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no end of run exp finish within 50000 cycles");
    $fatal(1);
  end

endmodule
